// File: rtl/rx_pkg.sv
// Shared types and default parameters for the UART RX control path.
package rx_pkg;

  localparam int unsigned RX_CLKS_PER_BIT = 10;
  localparam int unsigned RX_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    RECEIVE  = 3'd2,
    STOP_CHK = 3'd3,
    ERR_CHK  = 3'd4,
    LOAD     = 3'd5
  } rx_state_t;

endpackage

// File: rtl/rx_bit_timer.sv
// Bit-period timer: cycle counter within a bit and period index within a frame.
module rx_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = rx_pkg::RX_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = rx_pkg::RX_DATA_BITS,
  localparam int unsigned CNT_W       = $clog2(CLKS_PER_BIT),
  localparam int unsigned P_W         = $clog2(DATA_BITS + 2)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] cnt,
  output logic [P_W-1:0]   p,
  output logic             mid_bit,
  output logic             last_period
);

  localparam int unsigned HALF = CLKS_PER_BIT >> 1;

  // cnt wraps every bit period and advances p; the FSM leaves before p can wrap
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt <= '0;
      p   <= '0;
    end else if (clear) begin
      cnt <= '0;
      p   <= '0;
    end else if (enable) begin
      if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
        cnt <= '0;
        p   <= p + P_W'(1);
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign mid_bit     = (cnt == CNT_W'(HALF));
  assign last_period = (p == P_W'(DATA_BITS + 1));

endmodule

// File: rtl/rx_ctrl_unit.sv
// UART RX control FSM: frame timing, shift strobes, stop-bit checker handshake,
// buffer load. Optional start-bit glitch rejection: RX_CTRL_START_VERIFY_EN.
module rx_ctrl_unit #(
  parameter int unsigned CLKS_PER_BIT = rx_pkg::RX_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = rx_pkg::RX_DATA_BITS
) (
  input  logic clk,
  input  logic n_rst,
  input  logic start_bit_detected,
  input  logic serial_in,
  input  logic framing_error,
  output logic sbc_clear,
  output logic sbc_enable,
  output logic shift_strobe,
  output logic load_buffer,
  output logic rx_busy
);

  import rx_pkg::*;

  localparam int unsigned HALF  = CLKS_PER_BIT >> 1;
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned P_W   = $clog2(DATA_BITS + 2);

  rx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [P_W-1:0]   p;
  logic             mid_bit;
  logic             last_period;
  logic             pre_mid;
  logic             p_nz;

  rx_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .DATA_BITS    (DATA_BITS)
  ) u_timer (
    .clk         (clk),
    .n_rst       (n_rst),
    .clear       (state == START),
    .enable      (state == RECEIVE),
    .cnt         (cnt),
    .p           (p),
    .mid_bit     (mid_bit),
    .last_period (last_period)
  );

  // Strobe is registered, so it is launched one cycle ahead of the mid-bit count
  assign pre_mid = (cnt == CNT_W'(HALF - 1));
  assign p_nz    = (p != '0);

`ifndef RX_CTRL_START_VERIFY_EN
  logic unused_serial_in;
  assign unused_serial_in = serial_in;
`endif

  // Frame sequencing; each output register reflects the state being entered
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      sbc_clear    <= 1'b0;
      sbc_enable   <= 1'b0;
      shift_strobe <= 1'b0;
      load_buffer  <= 1'b0;
      rx_busy      <= 1'b0;
    end else begin
      sbc_clear    <= 1'b0;
      sbc_enable   <= 1'b0;
      shift_strobe <= 1'b0;
      load_buffer  <= 1'b0;
      rx_busy      <= 1'b1;
      case (state)
        IDLE: begin
          if (start_bit_detected) begin
            state     <= START;
            sbc_clear <= 1'b1;
          end else begin
            rx_busy <= 1'b0;
          end
        end
        START: begin
          state <= RECEIVE;
        end
        RECEIVE: begin
          if (mid_bit && last_period) begin
            state      <= STOP_CHK;
            sbc_enable <= 1'b1;
          end
`ifdef RX_CTRL_START_VERIFY_EN
          else if (mid_bit && !p_nz && serial_in) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
`endif
          else if (pre_mid && p_nz) begin
            shift_strobe <= 1'b1;
          end
        end
        STOP_CHK: begin
          state <= ERR_CHK;
        end
        ERR_CHK: begin
          if (framing_error) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end else begin
            state       <= LOAD;
            load_buffer <= 1'b1;
          end
        end
        LOAD: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_ctrl_unit.sv
// Directed bench for rx_ctrl_unit at default parameters (10 clocks/bit, 8 data bits).
module tb_rx_ctrl_unit;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic start_bit_detected = 1'b0;
  logic serial_in = 1'b0;
  logic framing_error;
  logic sbc_clear, sbc_enable, shift_strobe, load_buffer, rx_busy;

  rx_ctrl_unit dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .start_bit_detected (start_bit_detected),
    .serial_in          (serial_in),
    .framing_error      (framing_error),
    .sbc_clear          (sbc_clear),
    .sbc_enable         (sbc_enable),
    .shift_strobe       (shift_strobe),
    .load_buffer        (load_buffer),
    .rx_busy            (rx_busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Stop-bit checker stand-in: cleared by sbc_clear, flags a zero stop bit on sbc_enable
  logic stop_val = 1'b1;
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst)          framing_error <= 1'b0;
    else if (sbc_clear)  framing_error <= 1'b0;
    else if (sbc_enable) framing_error <= ~stop_val;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Event log: cycle numbers at which each output was seen high
  int stb_q[$], clr_q[$], en_q[$], ld_q[$], idle_q[$];
  int busy_cnt = 0;
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    if (shift_strobe) stb_q.push_back(cyc);
    if (sbc_clear)    clr_q.push_back(cyc);
    if (sbc_enable)   en_q.push_back(cyc);
    if (load_buffer)  ld_q.push_back(cyc);
    if (rx_busy)      busy_cnt++;
    if (prev_busy && !rx_busy) idle_q.push_back(cyc);
    prev_busy = rx_busy;
  end

  typedef struct {
    string name;
    logic  stop;
    int    xs1, xs2;
    int    gcyc;
    logic  gval;
    int    n_stb, stb0, en, n_ld, ld, idle;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_log();
    stb_q.delete(); clr_q.delete(); en_q.delete(); ld_q.delete(); idle_q.delete();
    busy_cnt = 0;
  endtask

  // Raise start so it is sampled at edge T, then run ncyc cycles of line stimulus
  task automatic run_frame(input vec_t v, input int ncyc, output int t);
    int c;
    @(posedge clk);
    clear_log();
    stop_val = v.stop;
    @(negedge clk);
    t = cyc;
    start_bit_detected = 1'b1;
    serial_in = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      c = cyc - t;
      start_bit_detected = (c == v.xs1) || (c == v.xs2);
      serial_in = (c == v.gcyc) ? v.gval : 1'b0;
    end
    start_bit_detected = 1'b0;
    serial_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t;
    int gaps;
    vec_t v;

    vecs[0] = '{"good_a5",   1'b1, -1, -1, -1, 1'b0, 9, 17, 98, 1, 100, 101};
    vecs[1] = '{"bad_stop",  1'b0, -1, -1, -1, 1'b0, 9, 17, 98, 0,  -1, 100};
    vecs[2] = '{"busy_start",1'b1, 30, 99, -1, 1'b0, 9, 17, 98, 1, 100, 101};
`ifdef RX_CTRL_START_VERIFY_EN
    vecs[3] = '{"glitch_1",  1'b1, -1, -1,  7, 1'b1, 0, -1, -1, 0,  -1,   8};
`else
    vecs[3] = '{"glitch_1",  1'b1, -1, -1,  7, 1'b1, 9, 17, 98, 1, 100, 101};
`endif
    vecs[4] = '{"glitch_0",  1'b1, -1, -1,  7, 1'b0, 9, 17, 98, 1, 100, 101};

    // Reset values
    #1;
    check("rst_sbc_clear",    int'(sbc_clear),    0);
    check("rst_sbc_enable",   int'(sbc_enable),   0);
    check("rst_shift_strobe", int'(shift_strobe), 0);
    check("rst_load_buffer",  int'(load_buffer),  0);
    check("rst_rx_busy",      int'(rx_busy),      0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);

    // Table-driven single frames
    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i], 125, t);
      gaps = 0;
      for (int j = 1; j < stb_q.size(); j++)
        if (stb_q[j] - stb_q[j-1] != 10) gaps++;
      check({vecs[i].name, "/clr_at"},   (clr_q.size() > 0) ? clr_q[0] - t : -1, 1);
      check({vecs[i].name, "/clr_cnt"},  clr_q.size(), 1);
      check({vecs[i].name, "/n_stb"},    stb_q.size(), vecs[i].n_stb);
      check({vecs[i].name, "/stb0"},     (stb_q.size() > 0) ? stb_q[0] - t : -1, vecs[i].stb0);
      check({vecs[i].name, "/stb_gap"},  gaps, 0);
      check({vecs[i].name, "/en_at"},    (en_q.size() > 0) ? en_q[0] - t : -1, vecs[i].en);
      check({vecs[i].name, "/n_ld"},     ld_q.size(), vecs[i].n_ld);
      check({vecs[i].name, "/ld_at"},    (ld_q.size() > 0) ? ld_q[0] - t : -1, vecs[i].ld);
      check({vecs[i].name, "/idle_at"},  (idle_q.size() > 0) ? idle_q[0] - t : -1, vecs[i].idle);
      check({vecs[i].name, "/busy_len"}, busy_cnt, vecs[i].idle - 1);
    end

    // Back-to-back: second start sampled in the first frame's trailing IDLE cycle
    v = vecs[0];
    v.xs1 = 101;
    run_frame(v, 230, t);
    check("b2b/clr_cnt",  clr_q.size(), 2);
    check("b2b/clr2_at",  (clr_q.size() > 1) ? clr_q[1] - t : -1, 102);
    check("b2b/n_stb",    stb_q.size(), 18);
    check("b2b/stb10_at", (stb_q.size() > 9) ? stb_q[9] - t : -1, 118);
    check("b2b/stb18_at", (stb_q.size() > 17) ? stb_q[17] - t : -1, 198);
    check("b2b/en2_at",   (en_q.size() > 1) ? en_q[1] - t : -1, 199);
    check("b2b/n_ld",     ld_q.size(), 2);
    check("b2b/ld2_at",   (ld_q.size() > 1) ? ld_q[1] - t : -1, 201);
    check("b2b/idle1_at", (idle_q.size() > 0) ? idle_q[0] - t : -1, 101);
    check("b2b/idle2_at", (idle_q.size() > 1) ? idle_q[1] - t : -1, 202);

    // Reset asserted in the middle of RECEIVE
    @(posedge clk);
    clear_log();
    stop_val = 1'b1;
    @(negedge clk);
    t = cyc;
    start_bit_detected = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      start_bit_detected = 1'b0;
    end
    check("midrst/busy_before", int'(rx_busy), 1);
    n_rst = 1'b0;
    #1;
    check("midrst/sbc_clear",    int'(sbc_clear),    0);
    check("midrst/sbc_enable",   int'(sbc_enable),   0);
    check("midrst/shift_strobe", int'(shift_strobe), 0);
    check("midrst/load_buffer",  int'(load_buffer),  0);
    check("midrst/rx_busy",      int'(rx_busy),      0);
    @(negedge clk);
    n_rst = 1'b1;
    clear_log();
    repeat (120) @(negedge clk);
    check("midrst/n_ld_after",  ld_q.size(),  0);
    check("midrst/n_stb_after", stb_q.size(), 0);
    check("midrst/n_en_after",  en_q.size(),  0);
    check("midrst/busy_after",  busy_cnt,     0);

    // A fresh frame still runs normally after the aborted one
    run_frame(vecs[0], 125, t);
    check("post_rst/n_stb", stb_q.size(), 9);
    check("post_rst/ld_at", (ld_q.size() > 0) ? ld_q[0] - t : -1, 100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
